// File: rtl/fifo_beat_packer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_beat_packer
// Purpose  : Pops narrow FIFO words and packs RATIO of them into one wide
//            beat on a registered valid/ready stream; flush closes a partial.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_beat_packer #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fifo_empty,
    input  logic [WIDTH-1:0]           fifo_data,
    output logic                       fifo_pop,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH*RATIO-1:0]     out_data,
    output logic [$clog2(RATIO+1)-1:0] out_count,
    output logic                       out_last
);

    localparam int c_FILL_W  = $clog2(RATIO);
    localparam int c_COUNT_W = $clog2(RATIO+1);
    localparam logic [c_FILL_W-1:0] c_FILL_MAX = c_FILL_W'(RATIO-1);

    logic [WIDTH*RATIO-1:0] r_acc;
    logic [c_FILL_W-1:0]    r_fill;
    logic                   r_flush_pend;
    logic                   r_out_valid;
    logic [WIDTH*RATIO-1:0] r_out_data;
    logic [c_COUNT_W-1:0]   r_out_count;
    logic                   r_out_last;

    logic                   w_out_free;
    logic                   w_flush_req;
    logic                   w_last_slot;
    logic                   w_pop;
    logic [WIDTH*RATIO-1:0] w_acc_next;

    always_comb begin
        w_out_free  = !r_out_valid || out_ready;
        w_flush_req = flush || r_flush_pend;
        w_last_slot = (r_fill == c_FILL_MAX);
        // The last slot may only be filled when the output register can take the beat.
        w_pop       = !rst && !fifo_empty && !w_flush_req && (!w_last_slot || w_out_free);
        w_acc_next  = r_acc;
        for (int i = 0; i < RATIO; i++) begin
            if (r_fill == c_FILL_W'(i)) begin
                w_acc_next[i*WIDTH +: WIDTH] = fifo_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc        <= '0;
            r_fill       <= '0;
            r_flush_pend <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_count  <= '0;
            r_out_last   <= 1'b0;
        end else begin
            // Acceptance drops valid unless a new beat loads below at the same edge.
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_pop) begin
                if (w_last_slot) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_acc_next;
                    r_out_count <= c_COUNT_W'(RATIO);
                    r_out_last  <= 1'b0;
                    r_acc       <= '0;
                    r_fill      <= '0;
                end else begin
                    r_acc  <= w_acc_next;
                    r_fill <= r_fill + c_FILL_W'(1);
                end
            end else if (w_flush_req) begin
                if (r_fill != '0) begin
                    if (w_out_free) begin
                        r_out_valid  <= 1'b1;
                        r_out_data   <= r_acc;
                        r_out_count  <= c_COUNT_W'(r_fill);
                        r_out_last   <= 1'b1;
                        r_acc        <= '0;
                        r_fill       <= '0;
                        r_flush_pend <= 1'b0;
                    end else begin
                        r_flush_pend <= 1'b1;
                    end
                end else begin
                    r_flush_pend <= 1'b0;
                end
            end
        end
    end

    assign fifo_pop  = w_pop;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;
    assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_fifo_beat_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_beat_packer
// Purpose  : Directed self-checking bench for fifo_beat_packer (WIDTH=8, RATIO=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_beat_packer;

    localparam int WIDTH = 8;
    localparam int RATIO = 4;

    logic        clk;
    logic        rst;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        fifo_pop;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_count;
    logic        out_last;

    int checks;
    int errors;

    // Simple FIFO model: the bench pushes, the DUT pops.
    logic [7:0] mem [0:63];
    logic [5:0] wr_ptr;
    logic [5:0] rd_ptr;
    int         pop_cnt;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_data  = mem[rd_ptr];

    always @(posedge clk) begin
        if (fifo_pop) begin
            rd_ptr  <= rd_ptr + 6'd1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    fifo_beat_packer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_pop   (fifo_pop),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_count  (out_count),
        .out_last   (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        mem[wr_ptr] = v;
        wr_ptr      = wr_ptr + 6'd1;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] d, input logic [2:0] c, input logic l);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"},  64'(out_data),  64'(d));
        chk({tag, "_count"}, 64'(out_count), 64'(c));
        chk({tag, "_last"},  64'(out_last),  64'(l));
    endtask

    int base;

    initial begin
        checks    = 0;
        errors    = 0;
        wr_ptr    = '0;
        rd_ptr    = '0;
        pop_cnt   = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset with a non-empty FIFO
        push(8'h11);
        #1;
        chk("rst_pop",   64'(fifo_pop),  64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data",  64'(out_data),  64'd0);
        chk("rst_count", 64'(out_count), 64'd0);
        chk("rst_last",  64'(out_last),  64'd0);
        tick();
        chk("rst_pop_hold", 64'(fifo_pop), 64'd0);

        // Full beat with sink ready
        push(8'h22); push(8'h33); push(8'h44);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("full_pop0", 64'(fifo_pop), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_pop", 64'(fifo_pop), 64'd1);
        end
        tick();
        chk_beat("full", 32'h44332211, 3'd4, 1'b0);
        chk("full_popcnt", 64'(pop_cnt), 64'd4);
        tick();
        chk("full_drop", 64'(out_valid), 64'd0);

        // Backpressure: 8 words, sink stalled
        out_ready = 1'b0;
        base      = pop_cnt;
        for (int v = 1; v <= 8; v++) push(8'(v));
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k >= 4) begin
                chk("bp_hold_valid", 64'(out_valid), 64'd1);
                chk("bp_hold_data",  64'(out_data),  64'h04030201);
            end
        end
        chk("bp_stall_pop",  64'(fifo_pop),       64'd0);
        chk("bp_stall_cnt",  64'(pop_cnt - base), 64'd7);
        chk("bp_head_kept",  64'(fifo_data),      64'h08);
        out_ready = 1'b1;
        #1;
        chk("bp_resume_pop", 64'(fifo_pop), 64'd1);
        tick();
        chk_beat("bp_beat2", 32'h08070605, 3'd4, 1'b0);
        tick();
        chk("bp_drop",     64'(out_valid),      64'd0);
        chk("bp_total",    64'(pop_cnt - base), 64'd8);
        chk("bp_empty",    64'(fifo_empty),     64'd1);

        // Partial flush: AA, BB then flush while CC waits in the FIFO
        push(8'hAA); push(8'hBB);
        tick();
        tick();
        push(8'hCC);
        flush = 1'b1;
        #1;
        chk("pf_no_pop", 64'(fifo_pop), 64'd0);
        tick();
        flush = 1'b0;
        chk_beat("pf", 32'h0000BBAA, 3'd2, 1'b1);

        // Flush while the output is blocked with fill = 1
        out_ready = 1'b0;
        tick();
        chk("fb_prior_data", 64'(out_data), 64'h0000BBAA);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fb_pend_valid", 64'(out_valid), 64'd1);
        chk("fb_pend_data",  64'(out_data),  64'h0000BBAA);
        chk("fb_pend_last",  64'(out_last),  64'd1);
        tick();
        chk("fb_still_prior", 64'(out_data), 64'h0000BBAA);
        out_ready = 1'b1;
        tick();
        chk_beat("fb", 32'h000000CC, 3'd1, 1'b1);

        // Flush with fill = 0 emits nothing
        tick();
        chk("ef_idle", 64'(out_valid), 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("ef_none1", 64'(out_valid), 64'd0);
        tick();
        chk("ef_none2", 64'(out_valid), 64'd0);

        // Flush at fill = RATIO-1: flush wins, fourth word stays in the FIFO
        push(8'hE1); push(8'hE2); push(8'hE3); push(8'hE4);
        tick(); tick(); tick();
        flush = 1'b1;
        #1;
        chk("bd_no_pop", 64'(fifo_pop), 64'd0);
        tick();
        flush = 1'b0;
        chk_beat("bd", 32'h00E3E2E1, 3'd3, 1'b1);
        chk("bd_head", 64'(fifo_data), 64'hE4);

        // Mid-beat reset after 3 pops (E4, 91, 92)
        tick();
        push(8'h91); push(8'h92);
        tick(); tick();
        chk("mr_pre_empty", 64'(fifo_empty), 64'd1);
        rst = 1'b1;
        #1;
        chk("mr_pop",   64'(fifo_pop),  64'd0);
        chk("mr_valid", 64'(out_valid), 64'd0);
        tick();
        rst = 1'b0;
        push(8'h55); push(8'h56); push(8'h57); push(8'h58);
        tick(); tick(); tick();
        chk("mr_no_early", 64'(out_valid), 64'd0);
        tick();
        chk_beat("mr", 32'h58575655, 3'd4, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
